// File: rtl/ssd1306_spi4_decoder_if.sv
// Pixel-byte write port: one addressed column byte per valid/ready transfer.
// Fields hold steady while valid is high and ready is low.
interface ssd1306_spi4_decoder_if #(
  parameter int COL_W  = 7,
  parameter int PAGE_W = 3
);
  logic              wr_valid;
  logic              wr_ready;
  logic [COL_W-1:0]  wr_col;
  logic [PAGE_W-1:0] wr_page;
  logic [7:0]        wr_data;

  modport master (output wr_valid, wr_col, wr_page, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_col, wr_page, wr_data, output wr_ready);
endinterface

// File: rtl/ssd1306_spi4_decoder.sv
// SSD1306 4-wire SPI decoder: oversampled framing, command/argument decode, windowed addressing.
// A byte completes 1 clk after its 8th sck edge; data arriving while the output is stalled is dropped (overrun).
module ssd1306_spi4_decoder #(
  parameter int DISP_WIDTH  = 128,
  parameter int DISP_HEIGHT = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cs_in,
  input  logic                   sck_i,
  input  logic                   sdi_i,
  input  logic                   dc_i,
  ssd1306_spi4_decoder_if.master wr,
  output logic                   disp_on_o,
  output logic                   inverse_o,
  output logic                   entire_on_o,
  output logic                   flip_x_o,
  output logic                   flip_y_o,
  output logic [1:0]             adr_mode_o,
  output logic                   cmd_err_o,
  output logic                   overrun_o
);

  localparam int COL_W  = (DISP_WIDTH > 1) ? $clog2(DISP_WIDTH) : 1;
  localparam int PAGES  = DISP_HEIGHT / 8;
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(DISP_WIDTH - 1);
  localparam logic [PAGE_W-1:0] PAGE_MAX = PAGE_W'(PAGES - 1);
  localparam logic [8:0]        COL_LIM  = 9'(DISP_WIDTH);
  localparam logic [8:0]        PAGE_LIM = 9'(PAGES);

  localparam logic [1:0] MODE_HORZ = 2'b00;
  localparam logic [1:0] MODE_VERT = 2'b01;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_BAD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, ARG_MODE, ARG_COL0, ARG_COL1, ARG_PAGE0, ARG_PAGE1
  } state_t;

  // cs synchronizer resets to the deasserted level so no frame is seen during reset
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, sdi_sync, dc_sync;
  logic cs_s, sck_s, sdi_s, dc_s, sck_prev, sck_rise;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      sdi_sync <= '0;
      dc_sync  <= '0;
      sck_prev <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_in};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_i};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi_i};
      dc_sync  <= {dc_sync[SYNC_STAGES-2:0], dc_i};
      sck_prev <= sck_s;
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;

  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       byte_done;
  logic [7:0] rx_dat;
  logic       rx_dc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt   <= '0;
      shift     <= '0;
      byte_done <= 1'b0;
      rx_dat    <= '0;
      rx_dc     <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shift   <= {shift[5:0], sdi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          rx_dat    <= {shift, sdi_s};
          rx_dc     <= dc_s;
        end
      end
    end
  end

  state_t            state, state_nxt;
  logic [7:0]        arg_dat, arg_nxt;
  logic [1:0]        mode, mode_nxt;
  logic              disp_on, disp_nxt, inverse, inv_nxt, entire_on, ent_nxt;
  logic              flip_x, fx_nxt, flip_y, fy_nxt;
  logic [COL_W-1:0]  col_start, col_start_nxt, col_end, col_end_nxt, col, col_nxt;
  logic [PAGE_W-1:0] page_start, page_start_nxt, page_end, page_end_nxt, page, page_nxt;
  logic              out_vld, vld_nxt;
  logic [COL_W-1:0]  out_col, ocol_nxt;
  logic [PAGE_W-1:0] out_page, opage_nxt;
  logic [7:0]        out_dat, odat_nxt;
  logic              overrun, ovr_nxt, cmd_err, err_nxt;
  logic              take_data;
  logic [7:0]        col_ext;

  always_comb begin
    state_nxt      = state;
    arg_nxt        = arg_dat;
    mode_nxt       = mode;
    disp_nxt       = disp_on;
    inv_nxt        = inverse;
    ent_nxt        = entire_on;
    fx_nxt         = flip_x;
    fy_nxt         = flip_y;
    col_start_nxt  = col_start;
    col_end_nxt    = col_end;
    page_start_nxt = page_start;
    page_end_nxt   = page_end;
    col_nxt        = col;
    page_nxt       = page;
    vld_nxt        = out_vld;
    ocol_nxt       = out_col;
    opage_nxt      = out_page;
    odat_nxt       = out_dat;
    ovr_nxt        = overrun;
    err_nxt        = 1'b0;
    take_data      = 1'b0;
    col_ext        = 8'(col);

    if (out_vld && wr.wr_ready) vld_nxt = 1'b0;

    if (byte_done) begin
      if (rx_dc) begin
        // a data byte aborts a pending argument but is still written out
        take_data = 1'b1;
        if (state != IDLE) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end else begin
        case (state)
          IDLE: begin
            case (rx_dat)
              8'hA4, 8'hA5: ent_nxt  = rx_dat[0];
              8'hA6, 8'hA7: inv_nxt  = rx_dat[0];
              8'hAE, 8'hAF: disp_nxt = rx_dat[0];
              8'hA0, 8'hA1: fx_nxt   = rx_dat[0];
              8'hC0:        fy_nxt   = 1'b0;
              8'hC8:        fy_nxt   = 1'b1;
              8'h20:        state_nxt = ARG_MODE;
              8'h21:        state_nxt = ARG_COL0;
              8'h22:        state_nxt = ARG_PAGE0;
              default: begin
                if (mode == MODE_PAGE) begin
                  if (rx_dat[7:3] == 5'b10110) begin
                    page_nxt = PAGE_W'(int'(rx_dat[2:0]) % PAGES);
                  end else if (rx_dat[7:4] == 4'h0) begin
                    col_ext[3:0] = rx_dat[3:0];
                    col_nxt      = col_ext[COL_W-1:0];
                  end else if (rx_dat[7:4] == 4'h1) begin
                    col_ext[7:4] = rx_dat[3:0];
                    col_nxt      = col_ext[COL_W-1:0];
                  end
                end
              end
            endcase
          end
          ARG_MODE: begin
            mode_nxt  = rx_dat[1:0];
            state_nxt = IDLE;
          end
          ARG_COL0: begin
            arg_nxt   = rx_dat;
            state_nxt = ARG_COL1;
          end
          ARG_COL1: begin
            if (arg_dat <= rx_dat && {1'b0, rx_dat} < COL_LIM) begin
              col_start_nxt = arg_dat[COL_W-1:0];
              col_end_nxt   = rx_dat[COL_W-1:0];
              col_nxt       = arg_dat[COL_W-1:0];
            end else begin
              err_nxt = 1'b1;
            end
            state_nxt = IDLE;
          end
          ARG_PAGE0: begin
            arg_nxt   = rx_dat;
            state_nxt = ARG_PAGE1;
          end
          ARG_PAGE1: begin
            if (arg_dat <= rx_dat && {1'b0, rx_dat} < PAGE_LIM) begin
              page_start_nxt = arg_dat[PAGE_W-1:0];
              page_end_nxt   = rx_dat[PAGE_W-1:0];
              page_nxt       = arg_dat[PAGE_W-1:0];
            end else begin
              err_nxt = 1'b1;
            end
            state_nxt = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end

    if (take_data && mode != MODE_BAD) begin
      if (out_vld && !wr.wr_ready) begin
        ovr_nxt = 1'b1;
      end else begin
        vld_nxt   = 1'b1;
        ocol_nxt  = col;
        opage_nxt = page;
        odat_nxt  = rx_dat;
        case (mode)
          MODE_HORZ: begin
            if (col == col_end) begin
              col_nxt  = col_start;
              page_nxt = (page == page_end) ? page_start : page + 1'b1;
            end else begin
              col_nxt = col + 1'b1;
            end
          end
          MODE_VERT: begin
            if (page == page_end) begin
              page_nxt = page_start;
              col_nxt  = (col == col_end) ? col_start : col + 1'b1;
            end else begin
              page_nxt = page + 1'b1;
            end
          end
          default: col_nxt = (col == COL_MAX) ? '0 : col + 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      arg_dat    <= '0;
      mode       <= MODE_PAGE;
      disp_on    <= 1'b0;
      inverse    <= 1'b0;
      entire_on  <= 1'b0;
      flip_x     <= 1'b0;
      flip_y     <= 1'b0;
      col_start  <= '0;
      col_end    <= COL_MAX;
      page_start <= '0;
      page_end   <= PAGE_MAX;
      col        <= '0;
      page       <= '0;
      out_vld    <= 1'b0;
      out_col    <= '0;
      out_page   <= '0;
      out_dat    <= '0;
      overrun    <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      arg_dat    <= arg_nxt;
      mode       <= mode_nxt;
      disp_on    <= disp_nxt;
      inverse    <= inv_nxt;
      entire_on  <= ent_nxt;
      flip_x     <= fx_nxt;
      flip_y     <= fy_nxt;
      col_start  <= col_start_nxt;
      col_end    <= col_end_nxt;
      page_start <= page_start_nxt;
      page_end   <= page_end_nxt;
      col        <= col_nxt;
      page       <= page_nxt;
      out_vld    <= vld_nxt;
      out_col    <= ocol_nxt;
      out_page   <= opage_nxt;
      out_dat    <= odat_nxt;
      overrun    <= ovr_nxt;
      cmd_err    <= err_nxt;
    end
  end

  assign wr.wr_valid = out_vld;
  assign wr.wr_col   = out_col;
  assign wr.wr_page  = out_page;
  assign wr.wr_data  = out_dat;
  assign disp_on_o   = disp_on;
  assign inverse_o   = inverse;
  assign entire_on_o = entire_on;
  assign flip_x_o    = flip_x;
  assign flip_y_o    = flip_y;
  assign adr_mode_o  = mode;
  assign cmd_err_o   = cmd_err;
  assign overrun_o   = overrun;

endmodule

// File: tb/tb_ssd1306_spi4_decoder.sv
// Bench for ssd1306_spi4_decoder: directed command/addressing cases, then random byte
// streams compared against a byte-level model of the display controller.
module tb_ssd1306_spi4_decoder;
  localparam int W = 128;
  localparam int PAGES = 8;

  logic clk = 1'b0, rst = 1'b1, cs = 1'b1, sck = 1'b0, sdi = 1'b0, dc = 1'b0;
  logic disp_on, inverse, entire_on, flip_x, flip_y, cmd_err, overrun;
  logic [1:0] adr_mode;

  ssd1306_spi4_decoder_if #(.COL_W(7), .PAGE_W(3)) bus();

  ssd1306_spi4_decoder #(.DISP_WIDTH(W), .DISP_HEIGHT(64), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .cs_in(cs), .sck_i(sck), .sdi_i(sdi), .dc_i(dc),
    .wr(bus),
    .disp_on_o(disp_on), .inverse_o(inverse), .entire_on_o(entire_on),
    .flip_x_o(flip_x), .flip_y_o(flip_y), .adr_mode_o(adr_mode),
    .cmd_err_o(cmd_err), .overrun_o(overrun)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  int obs_q[$];
  int obs_rd = 0, err_cnt = 0, hold_bad = 0, rdy_mode = 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pack(input int c, input int p, input int d);
    return (c << 11) | (p << 8) | (d & 255);
  endfunction

  function automatic int flags();
    return int'({disp_on, inverse, entire_on, flip_x, flip_y, adr_mode});
  endfunction

  // ready: 0 = held low, 1 = held high, 2 = random but never low for more than 3 cycles
  initial begin : rdy_drv
    int stall;
    stall = 0;
    bus.wr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) bus.wr_ready = 1'b0;
      else if (rdy_mode == 1) bus.wr_ready = 1'b1;
      else begin
        bus.wr_ready = (stall >= 3) ? 1'b1 : 1'($urandom % 2);
        stall = bus.wr_ready ? 0 : stall + 1;
      end
    end
  end

  initial begin : mon
    bit stall_prev;
    int held, cur;
    stall_prev = 1'b0;
    held = 0;
    forever begin
      @(negedge clk);
      if (rst) stall_prev = 1'b0;
      else begin
        cur = pack(int'(bus.wr_col), int'(bus.wr_page), int'(bus.wr_data));
        if (stall_prev && (!bus.wr_valid || cur != held)) hold_bad++;
        if (cmd_err) err_cnt++;
        if (bus.wr_valid && bus.wr_ready) obs_q.push_back(cur);
        stall_prev = bus.wr_valid && !bus.wr_ready;
        held = cur;
      end
    end
  end

  task automatic spi_bits(input logic [7:0] b, input logic d, input int nbits);
    for (int i = 7; i >= 8 - nbits; i--) begin
      sdi = b[i];
      dc  = d;
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic d);
    spi_bits(b, d, 8);
    repeat (12) @(posedge clk);
    #2;
  endtask

  task automatic cmd(input logic [7:0] b); spi_byte(b, 1'b0); endtask
  task automatic dat(input logic [7:0] b); spi_byte(b, 1'b1); endtask

  task automatic expect_wr(input string tag, input int c, input int p, input int d);
    chk(tag, (obs_rd < obs_q.size()) ? obs_q[obs_rd] : -1, pack(c, p, d));
    obs_rd++;
  endtask

  // byte-level reference model; st: 0 idle, 1 mode arg, 2/3 column args, 4/5 page args
  int m_st, m_arg, m_mode, m_cs, m_ce, m_ps, m_pe, m_col, m_page, m_err;
  bit m_disp, m_inv, m_ent, m_fx, m_fy;
  int exp_q[$];
  int exp_rd;

  task automatic m_reset();
    m_st = 0; m_arg = 0; m_mode = 2; m_cs = 0; m_ce = W - 1; m_ps = 0; m_pe = PAGES - 1;
    m_col = 0; m_page = 0; m_err = 0;
    m_disp = 0; m_inv = 0; m_ent = 0; m_fx = 0; m_fy = 0;
    exp_q.delete();
    exp_rd = 0;
  endtask

  function automatic int m_flags();
    return (int'(m_disp) << 6) | (int'(m_inv) << 5) | (int'(m_ent) << 4) |
           (int'(m_fx) << 3) | (int'(m_fy) << 2) | (m_mode & 3);
  endfunction

  task automatic m_data(input int b);
    if (m_mode == 3) return;
    exp_q.push_back(pack(m_col, m_page, b));
    if (m_mode == 0) begin
      if (m_col == m_ce) begin
        m_col = m_cs;
        m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % PAGES;
      end else m_col = (m_col + 1) % W;
    end else if (m_mode == 1) begin
      if (m_page == m_pe) begin
        m_page = m_ps;
        m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % W;
      end else m_page = (m_page + 1) % PAGES;
    end else m_col = (m_col + 1) % W;
  endtask

  task automatic m_byte(input int b, input bit d);
    if (d) begin
      if (m_st != 0) begin m_err++; m_st = 0; end
      m_data(b);
    end else begin
      case (m_st)
        0: begin
          if (b == 'hA4 || b == 'hA5) m_ent = b[0];
          else if (b == 'hA6 || b == 'hA7) m_inv = b[0];
          else if (b == 'hAE || b == 'hAF) m_disp = b[0];
          else if (b == 'hA0 || b == 'hA1) m_fx = b[0];
          else if (b == 'hC0) m_fy = 0;
          else if (b == 'hC8) m_fy = 1;
          else if (b == 'h20) m_st = 1;
          else if (b == 'h21) m_st = 2;
          else if (b == 'h22) m_st = 4;
          else if (m_mode == 2) begin
            if (b >= 'hB0 && b <= 'hB7) m_page = (b - 'hB0) % PAGES;
            else if (b < 'h10) m_col = ((m_col & 'hF0) | (b & 15)) & (W - 1);
            else if (b < 'h20) m_col = ((m_col & 'h0F) | ((b & 15) << 4)) & (W - 1);
          end
        end
        1: begin m_mode = b & 3; m_st = 0; end
        2: begin m_arg = b; m_st = 3; end
        3: begin
          if (m_arg <= b && b < W) begin m_cs = m_arg; m_ce = b; m_col = m_arg; end
          else m_err++;
          m_st = 0;
        end
        4: begin m_arg = b; m_st = 5; end
        default: begin
          if (m_arg <= b && b < PAGES) begin m_ps = m_arg; m_pe = b; m_page = m_arg; end
          else m_err++;
          m_st = 0;
        end
      endcase
    end
  endtask

  logic [7:0] cmd_tbl [0:13] = '{8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hAE, 8'hAF, 8'hA0,
                                 8'hA1, 8'hC0, 8'hC8, 8'h20, 8'h21, 8'h22, 8'hE3};

  task automatic pick(output int b, output bit d);
    int r;
    d = ($urandom % 10 == 0);
    if (m_st == 0) begin
      d = ($urandom % 100 < 45);
      r = $urandom % 20;
      if (d) b = $urandom % 256;
      else if (r < 14) b = int'(cmd_tbl[r]);
      else if (r < 17) b = 'hB0 + $urandom % 8;
      else if (r < 19) b = $urandom % 32;
      else b = $urandom % 256;
    end else if (d) b = $urandom % 256;
    else if (m_st == 1) b = ($urandom % 8 == 0) ? 3 : $urandom_range(0, 2);
    else if (m_st == 3 && m_arg < W && $urandom % 4 != 0) b = $urandom_range(m_arg, W - 1);
    else if (m_st == 2 || m_st == 3) b = $urandom_range(0, W + 7);
    else if (m_st == 5 && m_arg < PAGES && $urandom % 4 != 0) b = $urandom_range(m_arg, PAGES - 1);
    else b = $urandom_range(0, PAGES + 1);
  endtask

  initial begin : main
    int e0, err_base, b;
    bit d;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", flags(), 'h02);
    chk("rst_vld", bus.wr_valid, 0);
    chk("rst_ovr", overrun, 0);
    cs = 1'b0;
    #40;

    cmd(8'hAF); cmd(8'hA7); cmd(8'hA1); cmd(8'hC8);
    chk("flags_set", flags(), 'h6E);

    cmd(8'h20); cmd(8'h00); cmd(8'h21); cmd(8'h02); cmd(8'h03);
    cmd(8'h22); cmd(8'h01); cmd(8'h02);
    dat(8'h11); dat(8'h22); dat(8'h33); dat(8'h44); dat(8'h55);
    expect_wr("h0", 2, 1, 'h11); expect_wr("h1", 3, 1, 'h22); expect_wr("h2", 2, 2, 'h33);
    expect_wr("h3", 3, 2, 'h44); expect_wr("h4", 2, 1, 'h55);

    e0 = err_cnt;
    cmd(8'h21); cmd(8'h05); cmd(8'h02);
    chk("win_err", err_cnt - e0, 1);
    dat(8'h66); dat(8'h77);
    expect_wr("keep0", 3, 1, 'h66); expect_wr("keep1", 2, 2, 'h77);
    e0 = err_cnt;
    cmd(8'h21); dat(8'h88);
    chk("arg_err", err_cnt - e0, 1);
    expect_wr("arg_dat", 3, 2, 'h88);

    cmd(8'h20); cmd(8'h01); cmd(8'h21); cmd(8'h00); cmd(8'h7F);
    cmd(8'h22); cmd(8'h00); cmd(8'h07);
    dat(8'hA1); dat(8'hA2); dat(8'hA3);
    chk("vert_mode", int'(adr_mode), 1);
    expect_wr("v0", 0, 0, 'hA1); expect_wr("v1", 0, 1, 'hA2); expect_wr("v2", 0, 2, 'hA3);

    cmd(8'h20); cmd(8'h02); cmd(8'hB3); cmd(8'h0F); cmd(8'h17);
    dat(8'hC1); dat(8'hC2);
    expect_wr("p0", 'h7F, 3, 'hC1); expect_wr("p1", 0, 3, 'hC2);

    cmd(8'h20); cmd(8'h00);
    rdy_mode = 0;
    dat(8'hD1);
    chk("bp_vld", bus.wr_valid, 1);
    chk("bp_ovr0", overrun, 0);
    dat(8'hD2);
    chk("bp_ovr1", overrun, 1);
    chk("bp_hold", pack(int'(bus.wr_col), int'(bus.wr_page), int'(bus.wr_data)), pack(1, 3, 'hD1));
    rdy_mode = 1;
    repeat (6) @(posedge clk);
    #2;
    expect_wr("bp_out", 1, 3, 'hD1);
    spi_bits(8'hFF, 1'b1, 5);
    cs = 1'b1; #60; cs = 1'b0; #40;
    dat(8'h5A);
    expect_wr("abort", 2, 3, 'h5A);
    chk("extra_wr", obs_q.size(), obs_rd);
    chk("ovr_sticky", overrun, 1);

    rdy_mode = 0;
    dat(8'h99);
    chk("rst_pre_vld", bus.wr_valid, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_vld", bus.wr_valid, 0);
    chk("arst_flags", flags(), 'h02);
    chk("arst_ovr", overrun, 0);
    #30 rst = 1'b0;
    rdy_mode = 2;
    m_reset();
    repeat (4) @(posedge clk);
    #2;
    err_base = err_cnt;
    obs_rd = obs_q.size();

    for (int n = 0; n < 300; n++) begin
      if ($urandom % 20 == 0) begin
        spi_bits(8'($urandom), 1'($urandom), $urandom_range(1, 7));
        cs = 1'b1; #60; cs = 1'b0; #40;
      end else if ($urandom % 20 == 0) begin
        cs = 1'b1; #60; cs = 1'b0; #40;
      end
      pick(b, d);
      m_byte(b, d);
      spi_byte(8'(b), d);
      chk("r_flags", flags(), m_flags());
      chk("r_ovr", overrun, 0);
      chk("r_errs", err_cnt - err_base, m_err);
      chk("r_wr_cnt", obs_q.size() - obs_rd, exp_q.size() - exp_rd);
      while (exp_rd < exp_q.size()) begin
        chk("r_wr", (obs_rd < obs_q.size()) ? obs_q[obs_rd] : -1, exp_q[exp_rd]);
        exp_rd++;
        obs_rd++;
      end
      obs_rd = obs_q.size();
    end
    chk("hold_stable", hold_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
